sim_capture_buffer: RTL and testbench

Capture stage between the PIFO scheduler's dequeue output and the simulation checker. The DUT's dequeue port cannot be stalled, so the block tags each dequeued entry with a sequence number and buffers it in a FIFO. It then presents entries to the checker over a valid/ready stream. It also counts entries lost to overflow and flags a stalled DUT through an idle watchdog, so a hung scheduler ends the regression instead of hanging it.

---
 rtl/sim_capture_buffer.sv | 157 +++++++++++++++
 tb/tb_sim_capture_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_capture_buffer.sv
// -----------------------------------------------------------------------------
// sim_capture_buffer
//
// Capture stage between the PIFO scheduler's dequeue port and the simulation
// checker. The scheduler cannot be stalled, so every dequeued entry is tagged
// with a sequence number and parked in a circular FIFO. The checker drains the
// FIFO over a valid/ready stream. Entries that arrive while the FIFO is full
// (and nothing is popped) are dropped and counted. An idle watchdog raises
// `timeout` when the scheduler goes quiet, so a hung run ends the regression.
//
// Ports
//   clk           sole clock, rising edge
//   rstn          asynchronous active-low reset
//   s_valid       dequeue strobe from the scheduler (no back-pressure)
//   s_data0       rank
//   s_data1       metadata
//   m_axis_valid  head entry available (occupancy != 0)
//   m_axis_ready  consumer accepts the head entry
//   m_axis_data0  sequence tag of the head entry
//   m_axis_data1  rank of the head entry
//   m_axis_data2  metadata of the head entry
//   occupancy     stored entries, 0 .. 2**DEPTH_WIDTH
//   drop_count    dropped entries, saturating at 16'hFFFF
//   overflow      sticky: at least one entry was dropped
//   timeout       sticky: the idle watchdog expired
// -----------------------------------------------------------------------------
module sim_capture_buffer #(
  parameter int unsigned DATA_0_WIDTH   = 16,
  parameter int unsigned DATA_1_WIDTH   = 32,
  parameter int unsigned DEPTH_WIDTH    = 4,
  parameter int unsigned SEQ_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  input  logic [DATA_0_WIDTH-1:0] s_data0,
  input  logic [DATA_1_WIDTH-1:0] s_data1,
  output logic                    m_axis_valid,
  input  logic                    m_axis_ready,
  output logic [SEQ_WIDTH-1:0]    m_axis_data0,
  output logic [DATA_0_WIDTH-1:0] m_axis_data1,
  output logic [DATA_1_WIDTH-1:0] m_axis_data2,
  output logic [DEPTH_WIDTH:0]    occupancy,
  output logic [15:0]             drop_count,
  output logic                    overflow,
  output logic                    timeout
);

  localparam int unsigned DEPTH  = 1 << DEPTH_WIDTH;
  localparam int unsigned PTR_W  = DEPTH_WIDTH + 1;
  localparam int unsigned WORD_W = SEQ_WIDTH + DATA_0_WIDTH + DATA_1_WIDTH;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W-1:0]  FULL_OCC    = PTR_W'(DEPTH);
  localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_CYCLES);

  logic [WORD_W-1:0]    mem [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [SEQ_WIDTH-1:0] seq_q,      seq_d;
  logic [15:0]          drop_q,     drop_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q,  timeout_d;
  logic                 armed_q,    armed_d;
  logic [IDLE_W-1:0]    idle_q,     idle_d;

  logic [PTR_W-1:0]     occ;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [WORD_W-1:0]    head_word;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign occ  = wr_ptr_q - rd_ptr_q;
  assign full = (occ == FULL_OCC);
  assign pop  = m_axis_valid && m_axis_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = s_valid && (!full || pop);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    armed_d    = armed_q;
    idle_d     = idle_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // The tag advances on dropped entries too, so drops show as tag gaps.
    if (s_valid) seq_d = seq_q + SEQ_WIDTH'(1);

    if (s_valid && !push) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    // Watchdog stays quiet until the scheduler has produced something.
    if (s_valid) begin
      armed_d = 1'b1;
      idle_d  = '0;
    end else if (armed_q && idle_q != TIMEOUT_VAL) begin
      idle_d  = idle_q + IDLE_W'(1);
    end
    timeout_d = timeout_q || (idle_d == TIMEOUT_VAL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of statement order.
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      armed_q    <= 1'b0;
      idle_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      armed_q    <= armed_d;
      idle_q     <= idle_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which words are live, and the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= {seq_q, s_data0, s_data1};
  end

  assign head_word    = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
  assign m_axis_valid = (occ != '0);

  // Masking keeps the outputs at zero after reset, before any word is written.
  assign m_axis_data0 = m_axis_valid ? head_word[WORD_W-1 -: SEQ_WIDTH] : '0;
  assign m_axis_data1 = m_axis_valid ? head_word[DATA_1_WIDTH +: DATA_0_WIDTH] : '0;
  assign m_axis_data2 = m_axis_valid ? head_word[DATA_1_WIDTH-1:0] : '0;

  assign occupancy  = occ;
  assign drop_count = drop_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sim_capture_buffer.sv
// -----------------------------------------------------------------------------
// tb_sim_capture_buffer
//
// Self-checking bench for sim_capture_buffer. The main instance (depth 16,
// 16-bit tags, watchdog of 10 cycles) is driven through a per-cycle task that
// keeps a scoreboard queue of expected FIFO contents plus a drop/overflow
// model. A second instance with 4-bit tags exercises tag wrap-around.
// -----------------------------------------------------------------------------
module tb_sim_capture_buffer;

  typedef struct packed {
    logic [15:0] seq;
    logic [15:0] rank;
    logic [31:0] meta;
  } entry_t;

  logic        clk;
  logic        rstn;

  logic        s_valid;
  logic [15:0] s_data0;
  logic [31:0] s_data1;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [15:0] m_axis_data0;
  logic [15:0] m_axis_data1;
  logic [31:0] m_axis_data2;
  logic [4:0]  occupancy;
  logic [15:0] drop_count;
  logic        overflow;
  logic        timeout;

  logic        w_valid;
  logic [15:0] w_data0;
  logic [31:0] w_data1;
  logic        w_out_valid;
  logic        w_ready;
  logic [3:0]  w_tag;
  logic [15:0] w_rank;
  logic [31:0] w_meta;
  logic [4:0]  w_occ;
  logic [15:0] w_drop;
  logic        w_ovf;
  logic        w_tmo;

  int          checks;
  int          errors;

  entry_t      sb[$];
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  logic        m_ovf;

  sim_capture_buffer #(
    .DATA_0_WIDTH  (16),
    .DATA_1_WIDTH  (32),
    .DEPTH_WIDTH   (4),
    .SEQ_WIDTH     (16),
    .TIMEOUT_CYCLES(10)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_valid     (s_valid),
    .s_data0     (s_data0),
    .s_data1     (s_data1),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_data0(m_axis_data0),
    .m_axis_data1(m_axis_data1),
    .m_axis_data2(m_axis_data2),
    .occupancy   (occupancy),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  sim_capture_buffer #(
    .DATA_0_WIDTH  (16),
    .DATA_1_WIDTH  (32),
    .DEPTH_WIDTH   (4),
    .SEQ_WIDTH     (4),
    .TIMEOUT_CYCLES(1000)
  ) u_wrap (
    .clk         (clk),
    .rstn        (rstn),
    .s_valid     (w_valid),
    .s_data0     (w_data0),
    .s_data1     (w_data1),
    .m_axis_valid(w_out_valid),
    .m_axis_ready(w_ready),
    .m_axis_data0(w_tag),
    .m_axis_data1(w_rank),
    .m_axis_data2(w_meta),
    .occupancy   (w_occ),
    .drop_count  (w_drop),
    .overflow    (w_ovf),
    .timeout     (w_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  task automatic clear_model();
    sb.delete();
    m_seq  = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  // Reset asserted and released away from clock edges; leaves time at posedge+1.
  task automatic apply_reset();
    s_valid      = 1'b0;
    s_data0      = '0;
    s_data1      = '0;
    m_axis_ready = 1'b0;
    w_valid      = 1'b0;
    w_data0      = '0;
    w_data1      = '0;
    w_ready      = 1'b1;
    rstn         = 1'b0;
    #3;
    @(posedge clk);
    #2;
    rstn = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
  endtask

  // One clock of the main DUT: drive inputs, compare outputs against the
  // scoreboard, update the model, advance to just after the next edge.
  task automatic cycle(input logic v, input logic [15:0] r, input logic [31:0] m,
                       input logic rdy);
    entry_t e;
    logic   exp_valid;
    s_valid      = v;
    s_data0      = r;
    s_data1      = m;
    m_axis_ready = rdy;
    exp_valid    = (sb.size() != 0);

    checks++;
    if (m_axis_valid !== exp_valid) begin
      errors++;
      $display("FAIL valid: got %b expected %b at %0t", m_axis_valid, exp_valid, $time);
    end
    checks++;
    if (occupancy !== 5'(sb.size())) begin
      errors++;
      $display("FAIL occupancy: got %0d expected %0d at %0t", occupancy, sb.size(), $time);
    end
    checks++;
    if (drop_count !== m_drop) begin
      errors++;
      $display("FAIL drop_count: got %0d expected %0d at %0t", drop_count, m_drop, $time);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
    end

    if (sb.size() != 0) begin
      e = sb[0];
      checks++;
      if ({m_axis_data0, m_axis_data1, m_axis_data2} !== {e.seq, e.rank, e.meta}) begin
        errors++;
        $display("FAIL head: got seq=%0d rank=%0d meta=%h expected seq=%0d rank=%0d meta=%h at %0t",
                 m_axis_data0, m_axis_data1, m_axis_data2, e.seq, e.rank, e.meta, $time);
      end
      if (rdy) void'(sb.pop_front());
    end

    if (v) begin
      if (sb.size() < 16) begin
        e.seq  = m_seq;
        e.rank = r;
        e.meta = m;
        sb.push_back(e);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      m_seq = m_seq + 16'd1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({m_axis_valid, overflow, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/ovf/tmo=%b%b%b expected 000", m_axis_valid, overflow, timeout);
    end
    checks++;
    if ({occupancy, drop_count} !== 21'd0) begin
      errors++;
      $display("FAIL reset_counts: got occ=%0d drop=%0d expected 0 0", occupancy, drop_count);
    end
    checks++;
    if ({m_axis_data0, m_axis_data1, m_axis_data2} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h expected zeros", m_axis_data0, m_axis_data1, m_axis_data2);
    end
  endtask

  task automatic test_basic_flow();
    logic [15:0] ranks [3];
    ranks[0] = 16'd5;
    ranks[1] = 16'd3;
    ranks[2] = 16'd9;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, ranks[i], 32'hA000_0000 + 32'(i), 1'b1);
      checks++;
      if (m_axis_valid !== 1'b1 || m_axis_data0 !== 16'(i) || m_axis_data1 !== ranks[i]) begin
        errors++;
        $display("FAIL basic_out: got v=%b seq=%0d rank=%0d expected v=1 seq=%0d rank=%0d",
                 m_axis_valid, m_axis_data0, m_axis_data1, i, ranks[i]);
      end
      checks++;
      if (occupancy > 5'd1) begin
        errors++;
        $display("FAIL basic_occ: got %0d expected at most 1", occupancy);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'(100 + i), ~32'(i), 1'b0);
    checks++;
    if (occupancy !== 5'd16 || drop_count !== 16'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_state: got occ=%0d drop=%0d ovf=%b expected 16 4 1",
               occupancy, drop_count, overflow);
    end
    checks++;
    if (m_axis_data0 !== 16'd0 || m_axis_data1 !== 16'd100) begin
      errors++;
      $display("FAIL bp_head: got seq=%0d rank=%0d expected 0 100", m_axis_data0, m_axis_data1);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b1, 16'd77, 32'h77, 1'b1);
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data0 !== 16'd20) begin
      errors++;
      $display("FAIL bp_next_tag: got v=%b seq=%0d expected v=1 seq=20", m_axis_valid, m_axis_data0);
    end
    cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 32'(i * 3), 1'b0);
    checks++;
    if (occupancy !== 5'd16) begin
      errors++;
      $display("FAIL full_fill: got occ=%0d expected 16", occupancy);
    end
    for (int i = 16; i < 21; i++) begin
      cycle(1'b1, 16'(i), 32'(i * 3), 1'b1);
      checks++;
      if (occupancy !== 5'd16 || drop_count !== 16'd0) begin
        errors++;
        $display("FAIL full_pushpop: got occ=%0d drop=%0d expected 16 0", occupancy, drop_count);
      end
    end
    // Head must now be tag 5: five pops, no gap.
    checks++;
    if (m_axis_data0 !== 16'd5) begin
      errors++;
      $display("FAIL full_head_tag: got %0d expected 5", m_axis_data0);
    end
    for (int i = 0; i < 17; i++) cycle(1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_seq_wrap();
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      w_valid = 1'b1;
      w_data0 = 16'(i);
      w_data1 = 32'(i);
      @(posedge clk);
      #1;
      checks++;
      if (w_out_valid !== 1'b1 || w_tag !== 4'(i % 16) || w_rank !== 16'(i)) begin
        errors++;
        $display("FAIL wrap_tag: got v=%b tag=%0d rank=%0d expected v=1 tag=%0d rank=%0d",
                 w_out_valid, w_tag, w_rank, i % 16, i);
      end
    end
    w_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (w_out_valid !== 1'b0 || w_drop !== 16'd0) begin
      errors++;
      $display("FAIL wrap_drain: got v=%b drop=%0d expected 0 0", w_out_valid, w_drop);
    end
  endtask

  task automatic test_watchdog();
    logic exp_tmo;
    // Disarmed: no input at all.
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, '0, '0, 1'b1);
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL wd_disarmed: got %b expected 0 after %0d idle cycles", timeout, i + 1);
      end
    end
    // One beat then idle: rises on the 10th idle edge and sticks.
    apply_reset();
    cycle(1'b1, 16'd1, 32'd1, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      cycle(1'b0, '0, '0, 1'b1);
      exp_tmo = (n >= 10);
      checks++;
      if (timeout !== exp_tmo) begin
        errors++;
        $display("FAIL wd_expire: got %b expected %b at idle edge %0d", timeout, exp_tmo, n);
      end
    end
    // Beat every 9 cycles keeps it quiet.
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 16'(k), 32'(k), 1'b1);
      for (int n = 0; n < 8; n++) begin
        cycle(1'b0, '0, '0, 1'b1);
        checks++;
        if (timeout !== 1'b0) begin
          errors++;
          $display("FAIL wd_periodic: got %b expected 0 in period %0d", timeout, k);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'(i), 32'(i), 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, '0, 1'b1);
    checks++;
    if (occupancy !== 5'd7 || drop_count !== 16'd4) begin
      errors++;
      $display("FAIL areset_pre: got occ=%0d drop=%0d expected 7 4", occupancy, drop_count);
    end
    s_valid      = 1'b0;
    m_axis_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (m_axis_valid !== 1'b0 || occupancy !== 5'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: got v=%b occ=%0d drop=%0d ovf=%b expected 0 0 0 0",
               m_axis_valid, occupancy, drop_count, overflow);
    end
    @(posedge clk);
    #2;
    rstn = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    cycle(1'b1, 16'd42, 32'h42, 1'b0);
    checks++;
    if (m_axis_valid !== 1'b1 || m_axis_data0 !== 16'd0 || m_axis_data1 !== 16'd42) begin
      errors++;
      $display("FAIL areset_tag: got v=%b seq=%0d rank=%0d expected 1 0 42",
               m_axis_valid, m_axis_data0, m_axis_data1);
    end
    cycle(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    clear_model();
    test_reset();
    test_basic_flow();
    test_backpressure();
    test_full_push_pop();
    test_seq_wrap();
    test_watchdog();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
